// File: rtl/freelist_pkg.sv
// Shared defaults for the rename free list and the reorder buffer.
// i_kill is {valid, one-hot branch mask}: valid sits at bit WIDTH_BRM, above the mask.
package freelist_pkg;

  localparam int WIDTH_REG_DEF = 7;
  localparam int WIDTH_BRM_DEF = 4;
  localparam int NUM_ARCH_DEF  = 32;
  localparam int LANES         = 4;

  typedef struct packed {
    logic                     valid;
    logic [WIDTH_BRM_DEF-1:0] mask;
  } kill_t;

  function automatic int kill_valid_bit(input int width_brm);
    return width_brm;
  endfunction

endpackage

// File: rtl/freelist_ringbuf.sv
// Free-tag storage: one entry per physical register, written and read four entries at a time.
module ringbuf
  import freelist_pkg::*;
#(
  parameter int WIDTH_REG = WIDTH_REG_DEF,
  parameter int NUM_ARCH  = NUM_ARCH_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH_REG-1:0]       wr_ptr,
  input  logic [LANES*WIDTH_REG-1:0] wr_data,
  input  logic [WIDTH_REG-1:0]       rd_ptr,
  output logic [LANES*WIDTH_REG-1:0] rd_data
);

  localparam int DEPTH = 2**WIDTH_REG;

  logic [WIDTH_REG-1:0] mem [DEPTH];

  // Tags not held by architectural registers start out free, in ascending order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= (i < DEPTH - NUM_ARCH) ? WIDTH_REG'(NUM_ARCH + i) : '0;
    end else if (wr_en) begin
      for (int k = 0; k < LANES; k++)
        mem[wr_ptr + WIDTH_REG'(k)] <= wr_data[k*WIDTH_REG +: WIDTH_REG];
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < LANES; k++)
      rd_data[k*WIDTH_REG +: WIDTH_REG] = mem[rd_ptr + WIDTH_REG'(k)];
  end

endmodule

// File: rtl/freelist.sv
// Rename free list: hands out four physical tags per cycle, takes four back from commit,
// and rewinds the allocation head from a branch snapshot on misprediction.
module freelist
  import freelist_pkg::*;
#(
  parameter int WIDTH_REG = WIDTH_REG_DEF,
  parameter int WIDTH_BRM = WIDTH_BRM_DEF,
  parameter int NUM_ARCH  = NUM_ARCH_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_alloc_en,
  output logic [LANES*WIDTH_REG-1:0] o_alloc_prd4x,
  output logic                       o_alloc_ready,
  input  logic                       i_com_en,
  input  logic [LANES*WIDTH_REG-1:0] i_com_prd4x,
  input  logic                       i_snap_en,
  input  logic [WIDTH_BRM-1:0]       i_snap_brm,
  input  logic [WIDTH_BRM:0]         i_kill,
  output logic [WIDTH_REG:0]         o_count,
  output logic                       o_err
);

  localparam int DEPTH  = 2**WIDTH_REG;
  localparam int PTR_W  = WIDTH_REG + 1;
  localparam int KILL_V = kill_valid_bit(WIDTH_BRM);

  logic [PTR_W-1:0] head, tail, count, head_upd, kill_head;
  logic [PTR_W-1:0] snap [WIDTH_BRM];
  logic             kill_active, alloc_fire, com_ok, err;

  assign count         = tail - head;
  assign o_count       = count;
  assign o_err         = err;
  assign o_alloc_ready = count >= PTR_W'(LANES);
  assign kill_active   = i_kill[KILL_V] & (|i_kill[WIDTH_BRM-1:0]);
  assign alloc_fire    = i_alloc_en & o_alloc_ready & ~kill_active;
  assign com_ok        = count <= PTR_W'(DEPTH - LANES);
  assign head_upd      = alloc_fire ? head + PTR_W'(LANES) : head;

  // Lowest-index mask bit wins when several branches are killed at once.
  always_comb begin
    kill_head = '0;
    for (int b = WIDTH_BRM - 1; b >= 0; b--)
      if (i_kill[b]) kill_head = snap[b];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head <= '0;
      tail <= PTR_W'(DEPTH - NUM_ARCH);
      err  <= 1'b0;
      for (int b = 0; b < WIDTH_BRM; b++) snap[b] <= '0;
    end else begin
      head <= kill_active ? kill_head : head_upd;
      if (i_com_en) begin
        if (com_ok) tail <= tail + PTR_W'(LANES);
        else        err  <= 1'b1;
      end
      if (i_snap_en && !kill_active) begin
        for (int b = 0; b < WIDTH_BRM; b++)
          if (i_snap_brm[b]) snap[b] <= head_upd;
      end
    end
  end

  ringbuf #(
    .WIDTH_REG (WIDTH_REG),
    .NUM_ARCH  (NUM_ARCH)
  ) u_ringbuf (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .wr_en   (i_com_en & com_ok),
    .wr_ptr  (tail[WIDTH_REG-1:0]),
    .wr_data (i_com_prd4x),
    .rd_ptr  (head[WIDTH_REG-1:0]),
    .rd_data (o_alloc_prd4x)
  );

endmodule
